// File: rtl/mux_scan_ctrl_if.sv
// Handshake and data bundle between the scan controller and its driver/mux side.
// The master side issues start/ch_mask and returns the mux output; the slave side is the controller.
interface mux_scan_ctrl_if;
    logic       start;
    logic [3:0] ch_mask;
    logic       mux_y;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] result;

    modport master (
        output start,
        output ch_mask,
        output mux_y,
        input  sel,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  ch_mask,
        input  mux_y,
        output sel,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of a 4:1 mux in ascending order, holding each for DWELL cycles
// and sampling the mux output at the end of every dwell into a 4-bit result word.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [2:0] lowest_set(input logic [3:0] bits);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            r = bits[i] ? {1'b1, 2'(i)} : r;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [3:0]       mask_r;
    logic [3:0]       mask_s;
    logic [1:0]       ch_r;
    logic [1:0]       ch_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [3:0]       result_r;
    logic [3:0]       result_s;
    logic [1:0]       sel_r;
    logic [1:0]       sel_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;

    logic [2:0]       first_s;
    logic [2:0]       higher_s;
    logic             last_s;

    // Only channels strictly above the current one are candidates, so a scan never wraps.
    assign first_s  = lowest_set(bus.ch_mask);
    assign higher_s = lowest_set(mask_r & (4'b1110 << ch_r));
    assign last_s   = (cnt_r == CNT_LAST);

    // State register plus the registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = first_s[2] ? ST_DWELL : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (last_s && !higher_s[2]) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DWELL;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: mask capture, channel stepping, dwell count and sampling.
    always_comb begin
        mask_s   = mask_r;
        ch_s     = ch_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    result_s = 4'b0000;
                    mask_s   = bus.ch_mask;
                    ch_s     = first_s[1:0];
                    cnt_s    = {CNT_W{1'b0}};
                end else begin
                    cnt_s    = cnt_r;
                end
            end
            ST_DWELL: begin
                if (last_s) begin
                    result_s[ch_r] = bus.mux_y;
                    cnt_s          = {CNT_W{1'b0}};
                    ch_s           = higher_s[2] ? higher_s[1:0] : ch_r;
                end else begin
                    cnt_s          = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_s = cnt_r;
            end
        endcase
    end

    // Output values for the next cycle, computed from the next state.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        sel_s  = 2'd0;
        if (state_s == ST_DWELL) begin
            busy_s = 1'b1;
            sel_s  = ch_s;
        end else begin
            busy_s = 1'b0;
            sel_s  = 2'd0;
        end
        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r   <= 4'b0000;
            ch_r     <= 2'd0;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= 4'b0000;
        end else begin
            mask_r   <= mask_s;
            ch_r     <= ch_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
        end
    end

    assign bus.sel    = sel_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: two controllers (DWELL=2 and DWELL=1) each driving a behavioural 4:1 mux,
// compared against a reference built from the channel mask and dwell time.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      start_v;
    logic [1:0][3:0] mask_v;
    logic [1:0][3:0] mux_i;
    logic [1:0][1:0] sel_o;
    logic [1:0]      busy_o;
    logic [1:0]      done_o;
    logic [1:0][3:0] res_o;

    int tests_run    = 0;
    int tests_failed = 0;

    mux_scan_ctrl_if bus_a ();
    mux_scan_ctrl_if bus_b ();

    assign bus_a.start   = start_v[0];
    assign bus_a.ch_mask = mask_v[0];
    assign bus_a.mux_y   = mux_i[0][bus_a.sel];
    assign sel_o[0]      = bus_a.sel;
    assign busy_o[0]     = bus_a.busy;
    assign done_o[0]     = bus_a.done;
    assign res_o[0]      = bus_a.result;

    assign bus_b.start   = start_v[1];
    assign bus_b.ch_mask = mask_v[1];
    assign bus_b.mux_y   = mux_i[1][bus_b.sel];
    assign sel_o[1]      = bus_b.sel;
    assign busy_o[1]     = bus_b.busy;
    assign done_o[1]     = bus_b.done;
    assign res_o[1]      = bus_b.result;

    mux_scan_ctrl #(.DWELL(2)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mux_scan_ctrl #(.DWELL(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    function automatic int dwell_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle for n cycles: no done, no busy, select parked at 0.
    task automatic quiet(input int d, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("idle_done", 8'(done_o[d]), 8'd0);
            check("idle_busy", 8'(busy_o[d]), 8'd0);
            check("idle_sel",  8'(sel_o[d]),  8'd0);
        end
    endtask

    // One scan; the expected select sequence lists each enabled channel DWELL times in ascending order.
    // disturb=n pulses start and rewrites ch_mask during cycle T+n.
    task automatic run_scan(input int d, input logic [3:0] mask, input logic [3:0] din, input int disturb);
        int q[$];
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                for (int r = 0; r < dwell_of(d); r++) q.push_back(ch);
            end
        end
        @(negedge clk);
        mux_i[d]   = din;
        mask_v[d]  = mask;
        start_v[d] = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            mask_v[d]  = 4'($urandom);
            check("scan_sel",  8'(sel_o[d]),  8'(q[i]));
            check("scan_busy", 8'(busy_o[d]), 8'd1);
            check("scan_done", 8'(done_o[d]), 8'd0);
            if (disturb == i + 1) begin
                start_v[d] = 1'b1;
                mask_v[d]  = 4'b0001;
            end
        end
        @(negedge clk);
        start_v[d] = 1'b0;
        check("done",        8'(done_o[d]), 8'd1);
        check("result",      8'(res_o[d]),  8'(din & mask));
        check("done_busy",   8'(busy_o[d]), 8'd0);
        check("done_sel",    8'(sel_o[d]),  8'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start_v = 2'b00;
        mask_v  = '0;
        mux_i   = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_sel",    8'(sel_o[d]),  8'd0);
            check("rst_busy",   8'(busy_o[d]), 8'd0);
            check("rst_done",   8'(done_o[d]), 8'd0);
            check("rst_result", 8'(res_o[d]),  8'd0);
        end
        rst = 1'b0;
        quiet(0, 2);

        // Full, sparse and empty masks at DWELL=2.
        run_scan(0, 4'b1111, 4'b1010, 0);
        quiet(0, 3);
        check("result_hold", 8'(res_o[0]), 8'h0a);
        run_scan(0, 4'b0101, 4'b0111, 0);
        quiet(0, 2);
        run_scan(0, 4'b0000, 4'b1111, 0);
        quiet(0, 2);

        // Start pulse and mask change mid-scan must not disturb it nor produce a second done.
        run_scan(0, 4'b1111, 4'b0110, 3);
        quiet(0, 10);

        // Reset at T+4 of a full scan.
        @(negedge clk);
        mux_i[0]   = 4'b1111;
        mask_v[0]  = 4'b1111;
        start_v[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (c == 4) begin
                check("mid_result", 8'(res_o[0]), 8'h01);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        check("mrst_sel",    8'(sel_o[0]),  8'd0);
        check("mrst_busy",   8'(busy_o[0]), 8'd0);
        check("mrst_done",   8'(done_o[0]), 8'd0);
        check("mrst_result", 8'(res_o[0]),  8'd0);
        quiet(0, 12);

        // Reset and start together: start is lost.
        @(negedge clk);
        rst        = 1'b1;
        start_v[0] = 1'b1;
        mask_v[0]  = 4'b1111;
        @(negedge clk);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        check("rs_busy", 8'(busy_o[0]), 8'd0);
        check("rs_done", 8'(done_o[0]), 8'd0);
        quiet(0, 10);

        // Back-to-back scans at DWELL=1, second start in the first IDLE cycle.
        run_scan(1, 4'b1111, 4'b0011, 0);
        run_scan(1, 4'b1111, 4'b1100, 0);
        quiet(1, 3);

        // Randomised scans on both controllers.
        for (int n = 0; n < 40; n++) begin
            int d;
            d = n % 2;
            run_scan(d, 4'($urandom), 4'($urandom), 0);
            if ($urandom_range(0, 1) == 1) quiet(d, 1);
        end
        quiet(0, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
